// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions used by the load/store unit: memi encodings,
// LSU state type and access-size helpers.
package rv32_pkg;

  localparam logic [2:0] MEMI_B  = 3'b000;
  localparam logic [2:0] MEMI_H  = 3'b001;
  localparam logic [2:0] MEMI_W  = 3'b010;
  localparam logic [2:0] MEMI_BU = 3'b100;
  localparam logic [2:0] MEMI_HU = 3'b101;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Unlisted memi codes fall back to a full-word access.
  function automatic lsu_size_t memi_size(input logic [2:0] memi);
    case (memi)
      MEMI_B, MEMI_BU: return SZ_B;
      MEMI_H, MEMI_HU: return SZ_H;
      default:         return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] memi, input logic [1:0] addr_lo);
    case (memi_size(memi))
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte enables and data
// replication, load lane extraction with sign/zero extension.
module lsu_align
  import rv32_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [2:0]            memi,
  input  logic [1:0]            addr_lo,
  input  logic [DW-1:0]         wdata,
  input  logic [DW-1:0]         rword,
  output logic [WORD_BYTES-1:0] be,
  output logic [DW-1:0]         wdata_rep,
  output logic [DW-1:0]         rdata_ext
);

  lsu_size_t   size;
  logic        sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size      = memi_size(memi);
    sext      = ~memi[2];
    byte_sel  = rword[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
    be        = '1;
    wdata_rep = wdata;
    rdata_ext = rword;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = sext ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = sext ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: request/grant/response handshake with data memory, stalls
// the core until done. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W.
module lsu_mem_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    memi,
  input  logic          mewe,
  input  logic          ws,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          misalign,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_gnt,
  input  logic          dm_rvalid,
  input  logic [DW-1:0] dm_rdata
);

  lsu_state_t    state_q, state_d;
  logic [2:0]    memi_q, memi_d;
  logic [1:0]    lo_q, lo_d;
  logic          dm_req_q, dm_req_d;
  logic          dm_we_q, dm_we_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [3:0]    dm_be_q, dm_be_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          misalign_q, misalign_d;

  logic          op;
  logic          trap;
  logic [2:0]    memi_a;
  logic [1:0]    lo_a;
  logic [3:0]    be_a;
  logic [DW-1:0] wrep_a;
  logic [DW-1:0] rext_a;

  assign op = ws | mewe;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(memi, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // One aligner serves both directions: live inputs while accepting in IDLE,
  // latched size/offset while extracting the response in WAIT.
  assign memi_a = (state_q == IDLE) ? memi : memi_q;
  assign lo_a   = (state_q == IDLE) ? addr[1:0] : lo_q;

  lsu_align #(
    .DW (DW)
  ) u_align (
    .memi      (memi_a),
    .addr_lo   (lo_a),
    .wdata     (wdata),
    .rword     (dm_rdata),
    .be        (be_a),
    .wdata_rep (wrep_a),
    .rdata_ext (rext_a)
  );

  always_comb begin
    state_d    = state_q;
    memi_d     = memi_q;
    lo_d       = lo_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (op) begin
          misalign_d = trap;
          if (trap) begin
            rdata_d = '0;
            state_d = DONE;
          end else begin
            memi_d     = memi;
            lo_d       = addr[1:0];
            dm_we_d    = mewe;
            dm_addr_d  = {addr[AW-1:2], 2'b00};
            dm_be_d    = mewe ? be_a : '1;
            dm_wdata_d = mewe ? wrep_a : '0;
            dm_req_d   = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (dm_gnt) begin
          dm_req_d = 1'b0;
          state_d  = dm_we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          rdata_d = rext_a;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      memi_q     <= '0;
      lo_q       <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_be_q    <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      memi_q     <= memi_d;
      lo_q       <= lo_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign stall    = op & (state_q != DONE);
  assign rdata    = rdata_q;
  assign misalign = misalign_q;
  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_be    = dm_be_q;
  assign dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: memory responder with programmable
// grant/response delays plus scoreboards of expected requests and results.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  memi;
  logic        mewe, ws;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt = 1'b0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = '0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .memi(memi), .mewe(mewe), .ws(ws), .addr(addr),
    .wdata(wdata), .stall(stall), .rdata(rdata), .misalign(misalign),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        has_req;
    req_t        req;
    logic [31:0] rdata;
    logic        mis;
    int          stalls;
  } exp_t;

  typedef struct {
    string       nm;
    logic [2:0]  m;
    logic        we;
    logic        ld;
    logic [31:0] a;
    logic [31:0] wd;
    int          gd;
    int          rd;
    logic [31:0] word;
  } case_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  req_t        obs_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_rdata = '0;

  int          gnt_dly = 0, rv_dly = 0, gnt_cnt = 0, rv_cnt = 0;
  logic        rv_pend = 1'b0, gnt_drv = 1'b0, inj_rv = 1'b0;
  logic [31:0] mem_word = '0;

  // Memory model, driven on the falling edge; a grant driven last cycle
  // while dm_req was high means the handshake completed at the rising edge.
  always @(negedge clk) begin
    dm_rdata = mem_word;
    if (rst) begin
      gnt_drv   = 1'b0;
      rv_pend   = 1'b0;
      gnt_cnt   = 0;
      dm_gnt    = 1'b0;
      dm_rvalid = inj_rv;
    end else begin
      if (gnt_drv) begin
        obs_q.push_back('{dm_we, dm_addr, dm_be, dm_wdata});
        if (!dm_we) begin
          rv_pend = 1'b1;
          rv_cnt  = 0;
        end
      end
      gnt_drv = 1'b0;
      dm_gnt  = 1'b0;
      if (dm_req) begin
        if (gnt_cnt == gnt_dly) begin
          dm_gnt  = 1'b1;
          gnt_drv = 1'b1;
          gnt_cnt = 0;
        end else gnt_cnt++;
      end
      dm_rvalid = inj_rv;
      if (rv_pend) begin
        if (rv_cnt == rv_dly) begin
          dm_rvalid = 1'b1;
          rv_pend   = 1'b0;
        end else rv_cnt++;
      end
    end
  end

  function automatic exp_t model(input case_t c);
    exp_t        e;
    int          sz, base;
    logic        trap;
    logic [31:0] v;
    sz   = (c.m == 3'b000 || c.m == 3'b100) ? 1 : (c.m == 3'b001 || c.m == 3'b101) ? 2 : 4;
    base = int'(c.a[1:0]) & ~(sz - 1);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(c.a[1:0]) % sz) != 0;
`endif
    e.has_req     = !trap;
    e.mis         = trap;
    e.req.we      = c.we;
    e.req.addr    = c.a & 32'hFFFF_FFFC;
    e.req.be      = 4'hF;
    e.req.wdata   = '0;
    if (c.we) begin
      for (int i = 0; i < 4; i++) begin
        e.req.be[i]          = (i >= base) && (i < base + sz);
        e.req.wdata[8*i +: 8] = c.wd[8*(i % sz) +: 8];
      end
    end
    if (trap) model_rdata = '0;
    else if (!c.we) begin
      v = c.word >> (8 * base);
      if (sz == 1)      v = c.m[2] ? {24'h0, v[7:0]}  : 32'($signed(v[7:0]));
      else if (sz == 2) v = c.m[2] ? {16'h0, v[15:0]} : 32'($signed(v[15:0]));
      model_rdata = v;
    end
    e.rdata  = model_rdata;
    e.stalls = trap ? 1 : (c.we ? 2 + c.gd : 3 + c.gd + c.rd);
    return e;
  endfunction

  // Drives one instruction from IDLE until the DONE cycle, then returns to IDLE.
  task automatic do_op(input case_t c, output int stalls, output logic [31:0] rd_o,
                       output logic mis_o, output logic req_o);
    gnt_dly = c.gd; rv_dly = c.rd; mem_word = c.word;
    memi = c.m; mewe = c.we; ws = c.ld; addr = c.a; wdata = c.wd;
    stalls = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (!stall) break;
      stalls++;
      @(negedge clk);
    end
    rd_o = rdata; mis_o = misalign; req_o = dm_req;
    mewe = 1'b0; ws = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mewe = 1'b0; ws = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (dm_req !== 1'b0)  begin n_bad++; $display("FAIL reset_dm_req: got %b want 0", dm_req); end
    n_cmp++; if (dm_we !== 1'b0)   begin n_bad++; $display("FAIL reset_dm_we: got %b want 0", dm_we); end
    n_cmp++; if (dm_addr !== '0)   begin n_bad++; $display("FAIL reset_dm_addr: got %h want 0", dm_addr); end
    n_cmp++; if (dm_be !== '0)     begin n_bad++; $display("FAIL reset_dm_be: got %b want 0", dm_be); end
    n_cmp++; if (dm_wdata !== '0)  begin n_bad++; $display("FAIL reset_dm_wdata: got %h want 0", dm_wdata); end
    n_cmp++; if (rdata !== '0)     begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    n_cmp++; if (stall !== 1'b0)   begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(negedge clk);
    #2 rst = 1'b0;
    model_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_accesses();
    case_t       tbl[$];
    exp_t        e;
    req_t        r;
    int          st;
    logic [31:0] rv;
    logic        mis, rq;
    tbl.push_back(case_t'{"sw_0x100",    3'b010, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0});
    tbl.push_back(case_t'{"sb_0x103",    3'b000, 1'b1, 1'b0, 32'h103, 32'h000000A5, 0, 0, 32'h0});
    tbl.push_back(case_t'{"sh_0x102",    3'b001, 1'b1, 1'b0, 32'h102, 32'h1234BEEF, 2, 0, 32'h0});
    tbl.push_back(case_t'{"lb_0x102",    3'b000, 1'b0, 1'b1, 32'h102, 32'h0,        0, 0, 32'h12F03456});
    tbl.push_back(case_t'{"lbu_0x102",   3'b100, 1'b0, 1'b1, 32'h102, 32'h0,        0, 0, 32'h12F03456});
    tbl.push_back(case_t'{"lh_0x103",    3'b001, 1'b0, 1'b1, 32'h103, 32'h0,        0, 1, 32'h12F03456});
    tbl.push_back(case_t'{"lhu_0x102",   3'b101, 1'b0, 1'b1, 32'h102, 32'h0,        1, 2, 32'h8001ABCD});
    tbl.push_back(case_t'{"lh_0x100",    3'b001, 1'b0, 1'b1, 32'h100, 32'h0,        0, 0, 32'h8001ABCD});
    tbl.push_back(case_t'{"sw_0x10a",    3'b010, 1'b1, 1'b0, 32'h10A, 32'hCAFEBABE, 0, 0, 32'h0});
    tbl.push_back(case_t'{"st_and_ld",   3'b010, 1'b1, 1'b1, 32'h10C, 32'h01020304, 0, 0, 32'hFFFFFFFF});
    tbl.push_back(case_t'{"sw_code111",  3'b111, 1'b1, 1'b0, 32'h110, 32'hA1B2C3D4, 0, 0, 32'h0});
    tbl.push_back(case_t'{"lw_0x101",    3'b010, 1'b0, 1'b1, 32'h101, 32'h0,        0, 0, 32'h89ABCDEF});
    tbl.push_back(case_t'{"lw_code011",  3'b011, 1'b0, 1'b1, 32'h118, 32'h0,        0, 0, 32'h80000080});
    tbl.push_back(case_t'{"lw_slow",     3'b010, 1'b0, 1'b1, 32'h114, 32'h0,        2, 3, 32'h76543210});
    foreach (tbl[i]) begin
      exp_q.push_back(model(tbl[i]));
      do_op(tbl[i], st, rv, mis, rq);
      e = exp_q.pop_front();
      n_cmp++; if (st !== e.stalls) begin n_bad++; $display("FAIL %s stall_cycles: got %0d want %0d", tbl[i].nm, st, e.stalls); end
      n_cmp++; if (rv !== e.rdata)  begin n_bad++; $display("FAIL %s rdata: got %h want %h", tbl[i].nm, rv, e.rdata); end
      n_cmp++; if (mis !== e.mis)   begin n_bad++; $display("FAIL %s misalign: got %b want %b", tbl[i].nm, mis, e.mis); end
      n_cmp++; if (rq !== 1'b0)     begin n_bad++; $display("FAIL %s dm_req_in_done: got %b want 0", tbl[i].nm, rq); end
      if (e.has_req) begin
        n_cmp++;
        if (obs_q.size() != 1) begin
          n_bad++; $display("FAIL %s req_count: got %0d want 1", tbl[i].nm, obs_q.size());
        end else begin
          r = obs_q.pop_front();
          n_cmp++;
          if (r !== e.req) begin
            n_bad++;
            $display("FAIL %s request we/addr/be/wdata: got %b/%h/%b/%h want %b/%h/%b/%h", tbl[i].nm,
                     r.we, r.addr, r.be, r.wdata, e.req.we, e.req.addr, e.req.be, e.req.wdata);
          end
        end
      end else begin
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL %s req_count: got %0d want 0", tbl[i].nm, obs_q.size()); end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_cyc[$];
    logic [31:0] exp_addr[$];
    logic [1:0]  want;
    logic [31:0] wa;
    req_t        r;
    exp_cyc = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
    exp_addr = '{32'h200, 32'h204};
    gnt_dly = 0;
    memi = 3'b010; mewe = 1'b1; ws = 1'b0; addr = 32'h200; wdata = 32'h55AA00FF;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      want = exp_cyc.pop_front();
      n_cmp++;
      if ({stall, dm_req} !== want) begin
        n_bad++; $display("FAIL b2b_cycle%0d stall/dm_req: got %b%b want %b", cyc, stall, dm_req, want);
      end
      if (cyc == 2) addr = 32'h204;
      @(negedge clk);
    end
    mewe = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_bad++; $display("FAIL b2b_req_count: got %0d want 2", obs_q.size());
    end else begin
      while (exp_addr.size() > 0) begin
        wa = exp_addr.pop_front();
        r = obs_q.pop_front();
        n_cmp++; if (r.addr !== wa) begin n_bad++; $display("FAIL b2b_addr: got %h want %h", r.addr, wa); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_in_wait();
    case_t       c;
    int          st;
    logic [31:0] rv;
    logic        mis, rq;
    gnt_dly = 0; rv_dly = 20; mem_word = 32'h55AA55AA;
    memi = 3'b010; mewe = 1'b0; ws = 1'b1; addr = 32'h300;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_wait_stall_before: got %b want 1", stall); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (dm_req !== 1'b0) begin n_bad++; $display("FAIL rst_wait_dm_req: got %b want 0", dm_req); end
    n_cmp++; if (rdata !== '0)    begin n_bad++; $display("FAIL rst_wait_rdata: got %h want 0", rdata); end
    ws = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    obs_q.delete();
    @(posedge clk);
    #1 inj_rv = 1'b1; mem_word = 32'hCAFEF00D;
    @(posedge clk);
    #1 inj_rv = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (rdata !== '0)    begin n_bad++; $display("FAIL rst_wait_rvalid_ignored: got %h want 0", rdata); end
    n_cmp++; if (stall !== 1'b0)  begin n_bad++; $display("FAIL rst_wait_stall_after: got %b want 0", stall); end
    n_cmp++; if (dm_req !== 1'b0) begin n_bad++; $display("FAIL rst_wait_no_req: got %b want 0", dm_req); end
    @(negedge clk);
    c = case_t'{"post_rst_sw", 3'b010, 1'b1, 1'b0, 32'h304, 32'h11223344, 0, 0, 32'h0};
    do_op(c, st, rv, mis, rq);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL rst_wait_idle_after: stall cycles got %0d want 2", st); end
    n_cmp++; if (rv !== '0) begin n_bad++; $display("FAIL rst_wait_rdata_hold: got %h want 0", rv); end
    obs_q.delete();
  endtask

  task automatic test_no_mem_op();
    memi = 3'b010; mewe = 1'b0; ws = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      addr = $urandom; wdata = $urandom;
      #1;
      n_cmp++;
      if ({stall, dm_req} !== 2'b00) begin
        n_bad++; $display("FAIL rtype_cycle%0d stall/dm_req: got %b%b want 00", cyc, stall, dm_req);
      end
      @(negedge clk);
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rtype_req_count: got %0d want 0", obs_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; memi = '0; mewe = 1'b0; ws = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_no_mem_op();
    test_accesses();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store unit that sits directly downstream of the main decoder in the RV32 core. It takes the decoder's memory controls (`memi`, `mewe`, `ws`), the ALU-computed address and the rs2 store data. It runs a request/grant/response handshake with a data memory that may take several cycles, and holds the core with `stall` until the access completes. Load data is returned sign- or zero-extended for the register-file write-back mux.

## Interface
Parameters:
- `AW`, 32, byte address width
- `DW`, 32, data width; only 32 is supported

Ports:
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `memi`  in  3  access size/sign from decoder: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W
- `mewe`  in  1  store request from decoder
- `ws`  in  1  load request from decoder (write-back select = memory)
- `addr`  in  AW  effective address from ALU
- `wdata`  in  DW  store data (rs2)
- `stall`  out  1  hold PC and register file; combinational
- `rdata`  out  DW  extended load result; valid while `state==DONE`
- `misalign`  out  1  misaligned-access flag; valid while `state==DONE`
- `dm_req`  out  1  memory request; registered
- `dm_we`  out  1  1 = write
- `dm_addr`  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- `dm_be`  out  4  byte enables
- `dm_wdata`  out  DW  lane-replicated store data
- `dm_gnt`  in  1  memory accepted request
- `dm_rvalid`  in  1  read data valid; earliest the cycle after `dm_gnt`
- `dm_rdata`  in  DW  raw read word

## Operation
- `op = ws | mewe`. If both are set, the store wins; a load is not performed.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if `op` is set, latch addr/memi/we/be/wdata and go to REQ. With a misaligned access and the macro enabled, go to DONE instead.
  - REQ: `dm_req=1` with stable address/be/we/wdata until `dm_gnt`. On grant, a store goes to DONE and a load goes to WAIT.
  - WAIT: on `dm_rvalid`, register the extended `dm_rdata` into `rdata` and go to DONE.
  - DONE: `stall=0` for exactly one cycle, then go to IDLE.
- `stall = op & (state != DONE)`. A non-memory instruction never stalls.
- Store byte enables:
  - SB: `be = 4'b0001 << addr[1:0]`, data `{4{wdata[7:0]}}`
  - SH: `be = addr[1] ? 1100 : 0011`, data `{2{wdata[15:0]}}`
  - SW: `be = 1111`
- Load extraction:
  - B/BU: lane `addr[1:0]`
  - H/HU: lane `addr[1]`
  - W: whole word
  - B/H are sign-extended; BU/HU are zero-extended.
- Loads drive `dm_be=1111`, `dm_we=0`, `dm_wdata=0`.

## Timing
- Reset values: state IDLE, `dm_req=0`, `dm_we=0`, `dm_addr=0`, `dm_be=0`, `dm_wdata=0`, `rdata=0`, `misalign=0`.
- Reset deasserts `dm_req` immediately; an in-flight response is ignored after reset.
- Minimum latency:
  - store: 3 cycles (IDLE, REQ with same-cycle gnt, DONE), i.e. 2 stalled cycles
  - load: 4 cycles (IDLE, REQ, WAIT, DONE), i.e. 3 stalled cycles
- `dm_req` stays high through any number of cycles with `dm_gnt` low, and drops the cycle after the grant.
- `dm_rvalid` while in REQ or IDLE is ignored.
- `rdata` holds its last value outside DONE.
- Back-to-back memory ops: DONE → IDLE → the next op is latched. A new request is never issued in the same cycle as DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]=1` or a word access with `addr[1:0]!=0` issues no memory request.
  - The FSM goes IDLE → DONE with `misalign=1` and `rdata=0`.
  - Stores are dropped.
- Undefined:
  - Low address bits below the access size are ignored: H uses `addr[1]`, W uses lane 0.
  - The access proceeds normally and `misalign` is tied to 0.

## Structure
- Shared package `rv32_pkg`:
  - `MEMI_B/H/W/BU/HU` encodings
  - `lsu_state_t` enum
  - constant `WORD_BYTES=4`
- Sub-module `lsu_align`, combinational, containing the byte-enable and store replication logic and the load extract/extend logic. The FSM and registers stay in `lsu_mem_ctrl`.

## Test plan
- SW `addr=0x100`, `wdata=0xDEADBEEF`, `dm_gnt` high after 2 cycles in REQ → `dm_be=1111`, `dm_addr=0x100`, `stall` high 3 cycles, DONE once.
- SB `addr=0x103`, `wdata=0x000000A5` → `dm_be=1000`, `dm_wdata=0xA5A5A5A5`, `dm_addr=0x100`.
- LB `addr=0x102`, `dm_rdata=0x12F03456`, rvalid 1 cycle after gnt → `rdata=0xFFFFFFF0`; the same access as LBU gives `0x000000F0`.
- LH `addr=0x103` with `LSU_MISALIGN_TRAP_EN` → no `dm_req`, `misalign=1`, `rdata=0`, `stall` high 1 cycle. Without the macro → `dm_req` at `0x100`, upper halfword returned.
- `rst` asserted while in WAIT, then `dm_rvalid` pulses → state IDLE, `dm_req=0`, `rdata=0`, response ignored.
- `ws=mewe=0` for an R-type instruction → `stall=0`, `dm_req` never asserted.
